pe_frc_gather: RTL

- Parametrised N-channel neighbour-force collector, the successor to the fixed-width PE-to-ring force buffering and output arbitration.
- Each PE channel writes force packets into its own FIFO. A round-robin arbiter drains the non-empty FIFOs into one registered output with a valid/ready handshake toward the ring.
- Adds per-channel almost-full back-pressure, overflow detection and output-side stall support.

---
 rtl/MD_pkg.sv | 15 +
 rtl/pe_frc_gather_if.sv | 33 +++
 rtl/frc_gather_fifo.sv | 68 ++++++
 rtl/pe_frc_gather.sv | 114 +++++++++++
 4 files changed

// File: rtl/MD_pkg.sv
// Shared MD-engine types: force packet layout and gather defaults.
// Urgent-priority arbitration is enabled with FRC_GATHER_URGENT_EN.
package MD_pkg;

    localparam int FRC_PKT_STRUCT_WIDTH = 32;
    localparam int GATHER_NUM_CH        = 8;

    typedef struct packed {
        logic [1:0] tag;
        logic [9:0] fz;
        logic [9:0] fy;
        logic [9:0] fx;
    } frc_pkt_t;

endpackage

// File: rtl/pe_frc_gather_if.sv
// PE-side write bus and ring-side output bus of the force gather block.
// Shared by pe_frc_gather (slave) and its driver (master).
interface pe_frc_gather_if
    import MD_pkg::*;
#(
    parameter int NUM_CH = GATHER_NUM_CH,
    parameter int DATA_W = FRC_PKT_STRUCT_WIDTH
);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        almost_full;
    logic [DATA_W-1:0]        out_data;
    logic [CW-1:0]            out_chan;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_CH-1:0]        overflow;
    logic                     all_empty;

    modport master (
        output in_data, in_valid, out_ready,
        input  almost_full, out_data, out_chan, out_valid,
        input  overflow, all_empty
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output almost_full, out_data, out_chan, out_valid,
        output overflow, all_empty
    );

endinterface

// File: rtl/frc_gather_fifo.sv
// Single-channel force FIFO with same-cycle push/pop and a registered
// almost-full flag; a full FIFO accepts a write when it is also popped.
module frc_gather_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_C = (AW+1)'(AF_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic [AW:0]       cnt_nxt;
    logic              do_wr;
    logic              do_rd;
    logic              af_q;

    assign empty = (cnt == '0);
    assign full  = cnt[AW];
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        cnt_nxt = cnt;
        unique case ({do_wr, do_rd})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            af_q   <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            cnt  <= cnt_nxt;
            af_q <= (cnt_nxt >= AF_C);
        end
    end

    // Storage is not reset; pointers alone define the contents.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data     = mem[rd_ptr];
    assign count       = cnt;
    assign almost_full = af_q;

endmodule

// File: rtl/pe_frc_gather.sv
// N-channel PE force collector: per-channel FIFOs drained round-robin
// into one registered output. FRC_GATHER_URGENT_EN adds almost-full priority.
module pe_frc_gather
    import MD_pkg::*;
#(
    parameter int NUM_CH    = GATHER_NUM_CH,
    parameter int DATA_W    = FRC_PKT_STRUCT_WIDTH,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 4
) (
    input logic            clk,
    input logic            rst,
    pe_frc_gather_if.slave bus
);
    localparam int CW = $clog2(NUM_CH);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] rd_data [NUM_CH];
    logic [AW:0]       cnt     [NUM_CH];
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] cnt_zero;
    logic [NUM_CH-1:0] af;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] ovf_q;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     pick;
    logic [CW-1:0]     idx_c;
    logic [DATA_W-1:0] out_data_q;
    logic [CW-1:0]     out_chan_q;
    logic              out_valid_q;
    logic              found;
    logic              load;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        frc_gather_fifo #(
            .DATA_W    (DATA_W),
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .wr_en       (bus.in_valid[g]),
            .wr_data     (bus.in_data[g*DATA_W +: DATA_W]),
            .rd_en       (pop[g]),
            .rd_data     (rd_data[g]),
            .count       (cnt[g]),
            .full        (full[g]),
            .empty       (empty[g]),
            .almost_full (af[g])
        );
        assign cnt_zero[g] = (cnt[g] == '0);
    end

    assign load = !out_valid_q || bus.out_ready;

    always_comb begin
        int idx;
        idx   = 0;
        idx_c = '0;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            idx_c = CW'(idx);
            if (!found && !empty[idx_c]) begin
                found = 1'b1;
                pick  = idx_c;
            end
        end
`ifdef FRC_GATHER_URGENT_EN
        // Descending scan so the lowest urgent channel is the last writer.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (af[CW'(i)] && !empty[CW'(i)]) begin
                found = 1'b1;
                pick  = CW'(i);
            end
        end
`endif
        pop = '0;
        if (load && found) pop[pick] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr      <= CW'(NUM_CH - 1);
            ovf_q       <= '0;
        end else begin
            ovf_q <= ovf_q | (bus.in_valid & full & ~pop);
            if (load) begin
                if (found) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= rd_data[pick];
                    out_chan_q  <= pick;
                    rr_ptr      <= pick;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_chan    = out_chan_q;
    assign bus.overflow    = ovf_q;
    assign bus.almost_full = af;
    assign bus.all_empty   = (&cnt_zero) && !out_valid_q;

endmodule
